parking_slot_controller: RTL
============================

Name: parking_slot_controller

Overview:
- Sequences entry and exit of the 4-slot car park.
- Allocates a free slot on entry and latches the check-in timestamp per slot from the shared 11-bit timer.
- On exit, computes elapsed time and fee, frees the slot, and times the entry/exit gate pulses.
- Sits between the gate buttons/sensors and the display/fee logic; it owns the per-slot check-in time registers.

Parameters:
- NSLOT, 4, number of slots (fixed at 4; slot index is 2 bits).
- TW, 11, timer/timestamp width.
- GATE_CYCLES, 8, cycles a gate output stays high (>=1).
- RATE, 1, fee per timer unit (1..32, keeps fee within 16 bits).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- timer  in  TW  free-running time count; wraps 2047->0.
- in_req  in  1  entry request, level.
- out_req  in  1  exit request, level.
- out_slot  in  2  slot being vacated, valid with out_req.
- in_ack  out  1  one-cycle pulse: entry accepted.
- in_slot  out  2  allocated slot; valid with in_ack, then held.
- out_ack  out  1  one-cycle pulse: exit accepted.
- fee  out  16  fee for last exit; valid with out_ack, then held.
- occupied  out  NSLOT  bit i = slot i occupied.
- full  out  1  &occupied.
- err  out  1  one-cycle pulse: rejected request.
- gate_in  out  1  entry gate open.
- gate_out  out  1  exit gate open.
- checkin_time  out  NSLOT*TW  packed timestamps, slot 0 in the LSBs.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: occupied, checkin_time, fee, in_slot, in_ack, out_ack, err, gate_in, gate_out. Gate counter 0.
- States: IDLE, GATE. Requests are sampled only in IDLE; requests asserted in GATE are ignored.
- Request priority: if out_req and in_req are both high in IDLE, the exit is served and the entry waits.
- Exit (IDLE, out_req=1, sampled at edge T):
  - If occupied[out_slot]=0: err=1 in cycle T+1; remain IDLE; no state change.
  - Else, at T+1:
    - out_ack=1.
    - fee = ((timer - checkin_time[out_slot]) mod 2^TW) * RATE, using the timer value sampled at T.
    - occupied[out_slot] cleared; that slot's timestamp is left unchanged.
    - gate_out=1; enter GATE.
- Entry (IDLE, in_req=1, out_req=0, sampled at T):
  - If full: err=1 at T+1; remain IDLE.
  - Else, at T+1:
    - in_ack=1.
    - in_slot = lowest-index free slot.
    - occupied bit set; checkin_time[slot] = timer sampled at T.
    - gate_in=1; enter GATE.
- GATE:
  - The active gate output stays high for exactly GATE_CYCLES cycles, starting at T+1.
  - Return to IDLE in the cycle the gate drops. Only one gate is high at a time.
- Requesters must drop the request after ack/err. A request still high when the block returns to IDLE is a new request.
- Elapsed time wraps: timer=5 with check-in 2040 gives elapsed 13. Equal timestamps give fee 0.
- in_slot and fee keep their last values until the next accepted transaction of the same kind.
- Reset asserted mid-GATE: gate drops immediately; all slots become free.

Test Plan:
- Reset, then in_req with timer=100, GATE_CYCLES=8 -> in_ack at T+1, in_slot=0, occupied=0001, slot-0 timestamp=100, gate_in high exactly 8 cycles.
- Four entries at timer 10/20/30/40, then a fifth in_req -> slots 0..3 filled in order, full=1, fifth request gives err pulse, no gate, occupied=1111.
- Slot 2 checked in at 2040; out_req with out_slot=2 at timer=5, RATE=1 -> out_ack, fee=13, occupied bit 2 cleared, gate_out 8 cycles.
- out_req for empty slot 3 -> err one cycle, fee/occupied unchanged, gate_out stays 0.
- in_req and out_req high together (slot 1 occupied, park full) -> exit served first; after GATE, entry allocates slot 1.
- rst_n pulled low during gate_in high -> asynchronous clear: gate_in=0, occupied=0000, checkin_time=0 without waiting for a clock edge.

Source files
------------

// File: rtl/parking_slot_controller_if.sv
// Request/acknowledge bundle between the gate buttons/sensors (master)
// and the parking slot controller (slave).
interface parking_slot_controller_if;
    logic        in_req;
    logic        out_req;
    logic [1:0]  out_slot;
    logic        in_ack;
    logic [1:0]  in_slot;
    logic        out_ack;
    logic [15:0] fee;
    logic        err;

    modport master (
        output in_req, out_req, out_slot,
        input  in_ack, in_slot, out_ack, fee, err
    );

    modport slave (
        input  in_req, out_req, out_slot,
        output in_ack, in_slot, out_ack, fee, err
    );
endinterface

// File: rtl/parking_slot_controller.sv
// Entry/exit sequencer for a 4-slot car park: allocates slots, stamps
// check-in times, computes exit fees and times the gate pulses.
module parking_slot_controller #(
    parameter int NSLOT       = 4,
    parameter int TW          = 11,
    parameter int GATE_CYCLES = 8,
    parameter int RATE        = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TW-1:0]         timer,
    parking_slot_controller_if.slave bus,
    output logic [NSLOT-1:0]      occupied,
    output logic                  full,
    output logic                  gate_in,
    output logic                  gate_out,
    output logic [NSLOT*TW-1:0]   checkin_time
);

    localparam int CW = $clog2(GATE_CYCLES + 1);

    typedef enum logic {IDLE, GATE} state_t;

    state_t                       state, state_next;
    logic [CW-1:0]                cnt, cnt_next;
    logic [NSLOT-1:0]             occ_next;
    logic [NSLOT-1:0][TW-1:0]     stamp, stamp_next;
    logic [1:0]                   in_slot_next;
    logic [15:0]                  fee_next;
    logic                         in_ack_next, out_ack_next, err_next;
    logic                         gate_in_next, gate_out_next;
    logic [1:0]                   free_slot;

    // Elapsed time is taken modulo 2^TW so a timer wrap still yields the true duration.
    function automatic logic [15:0] calc_fee(input logic [TW-1:0] now,
                                             input logic [TW-1:0] stamp_val);
        logic [TW-1:0] elapsed;
        elapsed  = now - stamp_val;
        calc_fee = 16'(32'(elapsed) * 32'(RATE));
    endfunction

    function automatic logic [1:0] lowest_free(input logic [NSLOT-1:0] occ);
        lowest_free = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!occ[i]) lowest_free = 2'(i);
        end
    endfunction

    assign free_slot    = lowest_free(occupied);
    assign full         = &occupied;
    assign checkin_time = stamp;

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        occ_next      = occupied;
        stamp_next    = stamp;
        in_slot_next  = bus.in_slot;
        fee_next      = bus.fee;
        in_ack_next   = 1'b0;
        out_ack_next  = 1'b0;
        err_next      = 1'b0;
        gate_in_next  = gate_in;
        gate_out_next = gate_out;

        case (state)
            IDLE: begin
                // Exit wins over a simultaneous entry request.
                if (bus.out_req) begin
                    if (occupied[bus.out_slot]) begin
                        out_ack_next            = 1'b1;
                        fee_next                = calc_fee(timer, stamp[bus.out_slot]);
                        occ_next[bus.out_slot]  = 1'b0;
                        gate_out_next           = 1'b1;
                        cnt_next                = CW'(GATE_CYCLES - 1);
                        state_next              = GATE;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (bus.in_req) begin
                    if (full) begin
                        err_next = 1'b1;
                    end else begin
                        in_ack_next           = 1'b1;
                        in_slot_next          = free_slot;
                        occ_next[free_slot]   = 1'b1;
                        stamp_next[free_slot] = timer;
                        gate_in_next          = 1'b1;
                        cnt_next              = CW'(GATE_CYCLES - 1);
                        state_next            = GATE;
                    end
                end
            end
            GATE: begin
                if (cnt == '0) begin
                    gate_in_next  = 1'b0;
                    gate_out_next = 1'b0;
                    state_next    = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            occupied    <= '0;
            stamp       <= '0;
            bus.in_slot <= '0;
            bus.fee     <= '0;
            bus.in_ack  <= 1'b0;
            bus.out_ack <= 1'b0;
            bus.err     <= 1'b0;
            gate_in     <= 1'b0;
            gate_out    <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            occupied    <= occ_next;
            stamp       <= stamp_next;
            bus.in_slot <= in_slot_next;
            bus.fee     <= fee_next;
            bus.in_ack  <= in_ack_next;
            bus.out_ack <= out_ack_next;
            bus.err     <= err_next;
            gate_in     <= gate_in_next;
            gate_out    <= gate_out_next;
        end
    end

endmodule
